// File: rtl/nanorv32_irq_ctrl.sv
// nanorv32_irq_ctrl
//
// Memory-mapped interrupt controller sitting between the wrapper's peripheral
// bus and the core irq[31:0] input. Each of 32 external sources is latched as
// an edge or level interrupt into PENDING; irq_out presents PENDING & MASK to
// the core, registered. Firmware acknowledges edge interrupts by writing 1s to
// PENDING (write-1-to-clear, byte-strobed).
//
// Register window (byte offset from BASE_ADDR, word index = mem_addr[7:2]):
//   0x00 PENDING  R / W1C
//   0x04 MASK     RW
//   0x08 EDGE     RW   (1 = edge-triggered, 0 = level)
//   0x0C LOAD     RW   (timer reload; reads 0 without the timer)
//   0x10 COUNT    RO   (timer down-counter; reads 0 without the timer)
//   anything else in the window reads 0, writes ignored
//
// Optional feature: define IRQ_TIMER_EN to build a periodic down-counter that
// sets PENDING[TIMER_IRQ] every LOAD cycles. Without it LOAD/COUNT do not
// exist and TIMER_IRQ is an ordinary external source.
//
// Ports:
//   clk        clock, rising edge
//   resetn     synchronous active-low reset
//   irq_in     raw interrupt sources, synchronous to clk
//   mem_valid  bus request, held until mem_ready
//   mem_addr   byte address
//   mem_wdata  write data
//   mem_wstrb  byte strobes, 0 = read
//   mem_ready  one-cycle completion pulse
//   mem_rdata  read data, valid while mem_ready is high
//   irq_out    registered PENDING & MASK to the core
//
// Bus FSM:
//   state  | meaning
//   S_IDLE | waiting for a request that hits the window; write commits on exit
//   S_ACK  | mem_ready/mem_rdata presented for exactly one cycle
module nanorv32_irq_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter logic [31:0] MASK_RESET = 32'h0000_0000,
    parameter logic [31:0] EDGE_RESET = 32'hFFFF_FFFF,
    parameter int          TIMER_IRQ  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] irq_in,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [31:0] irq_out
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } bus_state_t;

    localparam logic [5:0] OFF_PENDING = 6'h00;
    localparam logic [5:0] OFF_MASK    = 6'h01;
    localparam logic [5:0] OFF_EDGE    = 6'h02;
    localparam logic [5:0] OFF_LOAD    = 6'h03;
    localparam logic [5:0] OFF_COUNT   = 6'h04;

    bus_state_t  state;
    bus_state_t  state_next;
    logic        accept;

    logic [31:0] pending;
    logic [31:0] mask;
    logic [31:0] edge_sel;
    logic [31:0] irq_in_q;

    logic [31:0] pending_next;
    logic [31:0] mask_next;
    logic [31:0] edge_next;
    logic [31:0] rd_value;
    logic [31:0] timer_set;

    logic        hit;
    logic        wr_en;
    logic [5:0]  offset;
    logic [31:0] byte_mask;
    logic [31:0] w1c;
    logic [31:0] rise;

    // Byte-lane bits are ignored: registers are word-addressed.
    logic [1:0]  unused_addr_lsb;
    assign unused_addr_lsb = mem_addr[1:0];

    assign offset    = mem_addr[7:2];
    assign hit       = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]);
    assign byte_mask = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
                        {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
    assign wr_en     = accept && (mem_wstrb != 4'b0000);

    // ------------------------------------------------------------------
    // Bus FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (hit) begin
                    state_next = S_ACK;
                    accept     = 1'b1;
                end
            end
            S_ACK: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign mem_ready = (state == S_ACK);

    // ------------------------------------------------------------------
    // Optional timer
    // ------------------------------------------------------------------
`ifdef IRQ_TIMER_EN
    logic [31:0] load;
    logic [31:0] count;
    logic [31:0] load_next;
    logic [31:0] count_next;
    logic        load_wr;
    logic        timer_fire;

    assign load_wr    = wr_en && (offset == OFF_LOAD);
    assign load_next  = load_wr ? ((load & ~byte_mask) | (mem_wdata & byte_mask)) : load;
    assign timer_fire = (count == 32'd1);
    assign timer_set  = timer_fire ? (32'd1 << TIMER_IRQ) : 32'd0;

    // A LOAD write restarts the period from the new value; LOAD=0 parks
    // COUNT at 0, which never matches the terminal count.
    always_comb begin
        count_next = count;
        if (load_wr) begin
            count_next = load_next;
        end else if (count > 32'd1) begin
            count_next = count - 32'd1;
        end else if (timer_fire) begin
            count_next = load;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            load  <= 32'd0;
            count <= 32'd0;
        end else begin
            load  <= load_next;
            count <= count_next;
        end
    end
`else
    localparam int unused_timer_irq = TIMER_IRQ;
    assign timer_set = 32'd0;
`endif

    // ------------------------------------------------------------------
    // Register read mux (pre-write values)
    // ------------------------------------------------------------------
    always_comb begin
        rd_value = 32'd0;
        case (offset)
            OFF_PENDING: rd_value = pending;
            OFF_MASK:    rd_value = mask;
            OFF_EDGE:    rd_value = edge_sel;
`ifdef IRQ_TIMER_EN
            OFF_LOAD:    rd_value = load;
            OFF_COUNT:   rd_value = count;
`endif
            default:     rd_value = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Pending / mask / edge next-state
    // ------------------------------------------------------------------
    assign w1c  = (wr_en && (offset == OFF_PENDING)) ? (mem_wdata & byte_mask) : 32'd0;
    assign rise = irq_in & ~irq_in_q;

    assign mask_next = (wr_en && (offset == OFF_MASK))
                       ? ((mask & ~byte_mask) | (mem_wdata & byte_mask)) : mask;
    assign edge_next = (wr_en && (offset == OFF_EDGE))
                       ? ((edge_sel & ~byte_mask) | (mem_wdata & byte_mask)) : edge_sel;

    // Edge bits: clear applied before set, so a same-cycle rising edge wins.
    // Level bits mirror the synchronised source and ignore W1C entirely.
    // Mode selection uses the current EDGE so a mode change lands next cycle.
    assign pending_next = (edge_sel & ((pending & ~w1c) | rise))
                        | (~edge_sel & irq_in_q)
                        | timer_set;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending   <= 32'd0;
            mask      <= MASK_RESET;
            edge_sel  <= EDGE_RESET;
            irq_in_q  <= 32'd0;
            irq_out   <= 32'd0;
            mem_rdata <= 32'd0;
        end else begin
            pending   <= pending_next;
            mask      <= mask_next;
            edge_sel  <= edge_next;
            irq_in_q  <= irq_in;
            irq_out   <= pending_next & mask_next;
            mem_rdata <= accept ? rd_value : 32'd0;
        end
    end

endmodule

// File: tb/tb_nanorv32_irq_ctrl.sv
// Scoreboard bench for nanorv32_irq_ctrl. Reads push their expected data
// into a queue when issued; a monitor pops on every mem_ready. irq_out is
// compared each cycle against a behavioural model built from the register
// rules (per-bit edge/level rules, timer as absolute fire timestamps).
module tb_nanorv32_irq_ctrl;

    localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef IRQ_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] irq_in;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] irq_out;

    always #5 clk = ~clk;

    nanorv32_irq_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .irq_in    (irq_in),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .irq_out   (irq_out)
    );

    int vectors    = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    // model state
    logic [31:0] m_pend, m_mask, m_edge, m_load, m_inq, m_irq_out;
    longint      m_cyc, m_next_fire;
    bit          m_access;
    bit          rand_irq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_count();
        if (TIMER && m_load != 32'd0) return 32'(m_next_fire - m_cyc);
        return 32'd0;
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] off);
        case (off)
            6'd0: return m_pend;
            6'd1: return m_mask;
            6'd2: return m_edge;
            6'd3: return TIMER ? m_load : 32'd0;
            6'd4: return m_count();
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_pend = 0; m_mask = 32'h0; m_edge = 32'hFFFF_FFFF; m_load = 0;
        m_inq = 0; m_irq_out = 0; m_next_fire = 0;
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_step();
        logic [31:0] bm, w1c, newp;
        logic [5:0]  off;
        bit          hit, wr, fire, load_wr;
        longint      n;
        n = m_cyc + 1;
        m_cyc = n;
        if (!resetn) begin
            m_reset();
            return;
        end
        for (int b = 0; b < 4; b++) bm[b*8 +: 8] = {8{mem_wstrb[b]}};
        off = mem_addr[7:2];
        hit = m_access && mem_valid && (mem_addr[31:8] == BASE[31:8]);
        wr  = hit && (mem_wstrb != 4'd0);
        if (hit) exp_q.push_back(m_read(off));
        fire = TIMER && (m_load != 0) && (n == m_next_fire);
        w1c  = (wr && off == 6'd0) ? (mem_wdata & bm) : 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (m_edge[i]) newp[i] = (m_pend[i] && !w1c[i]) || (irq_in[i] && !m_inq[i]);
            else           newp[i] = m_inq[i];
            if (fire && i == 4) newp[i] = 1'b1;
        end
        if (wr && off == 6'd1) m_mask = (m_mask & ~bm) | (mem_wdata & bm);
        if (wr && off == 6'd2) m_edge = (m_edge & ~bm) | (mem_wdata & bm);
        load_wr = TIMER && wr && (off == 6'd3);
        if (fire) m_next_fire = n + longint'(m_load);
        if (load_wr) begin
            m_load = (m_load & ~bm) | (mem_wdata & bm);
            m_next_fire = n + longint'(m_load);
        end
        m_pend = newp;
        m_inq = irq_in;
        m_irq_out = newp & m_mask;
    endtask

    task automatic tick();
        if (rand_irq) irq_in = irq_in ^ ($urandom & $urandom & $urandom);
        model_step();
        @(posedge clk);
        #1;
        chk("irq_out", irq_out, m_irq_out);
        m_access = 1'b0;
    endtask

    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input bit expect_hit);
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
        m_access = 1'b1;
        tick();
        chk("ready_latency", 32'(mem_ready), 32'(expect_hit));
        if (expect_hit) tick();
        mem_valid = 1'b0; mem_wstrb = 4'd0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(mem_ready), 32'd0);
        resetn = 1'b1;
    endtask

    // monitor: pop one expectation per completion pulse
    initial begin
        forever begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_ready: got ready with rdata %h, expected none", mem_rdata);
                end else begin
                    chk("rdata", mem_rdata, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit found, stray;
        longint t_prev;
        logic [31:0] addr, wd;
        logic [3:0]  st;
        int w;

        resetn = 1'b0; irq_in = 0; mem_valid = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
        m_access = 0; rand_irq = 0; m_cyc = 0;
        m_reset();
        do_reset();

        // 1: masked pulse latches, read PENDING
        irq_in = 32'h20; tick();
        irq_in = 32'h0;  tick();
        bus(BASE + 32'h0, 32'h0, 4'h0, 1'b1);

        // 2: unmask via byte 0, pulse, acknowledge
        bus(BASE + 32'h0, 32'h20, 4'hF, 1'b1);
        bus(BASE + 32'h4, 32'hFFFF_FF20, 4'b0001, 1'b1);
        irq_in = 32'h20; tick();
        chk("t2_irq5", 32'(irq_out[5]), 32'd1);
        irq_in = 32'h0; tick();
        bus(BASE + 32'h0, 32'h20, 4'hF, 1'b1);
        chk("t2_cleared", irq_out, 32'h0);

        // 3: level source ignores W1C while high
        bus(BASE + 32'h8, 32'h0, 4'hF, 1'b1);
        irq_in = 32'h08; tick(); tick(); tick();
        bus(BASE + 32'h0, 32'h08, 4'hF, 1'b1);
        bus(BASE + 32'h0, 32'h0, 4'h0, 1'b1);
        irq_in = 32'h0; tick(); tick();
        bus(BASE + 32'h0, 32'h0, 4'h0, 1'b1);
        bus(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, 1'b1);

        // 4: rising edge same cycle as W1C -> set wins
        bus(BASE + 32'h0, 32'hFFFF_FFFF, 4'hF, 1'b1);
        irq_in = 32'h80;
        bus(BASE + 32'h0, 32'h80, 4'hF, 1'b1);
        bus(BASE + 32'h0, 32'h0, 4'h0, 1'b1);
        irq_in = 32'h0; tick();

        // miss: another slave's window
        bus(32'h2000_0004, 32'h0, 4'h0, 1'b0);

`ifdef IRQ_TIMER_EN
        // 5: periodic timer on bit 4
        bus(BASE + 32'h4, 32'h10, 4'hF, 1'b1);
        bus(BASE + 32'h0, 32'hFFFF_FFFF, 4'hF, 1'b1);
        bus(BASE + 32'hC, 32'd100, 4'hF, 1'b1);
        t_prev = -1;
        for (int k = 0; k < 3; k++) begin
            found = 0;
            for (int j = 0; j < 150 && !found; j++) begin
                tick();
                if (irq_out[4]) found = 1;
            end
            chk("timer_fire", 32'(found), 32'd1);
            if (k > 0) chk("timer_period", 32'(m_cyc - t_prev), 32'd100);
            t_prev = m_cyc;
            bus(BASE + 32'h0, 32'h10, 4'hF, 1'b1);
        end
        bus(BASE + 32'hC, 32'd0, 4'hF, 1'b1);
        stray = 0;
        for (int j = 0; j < 250; j++) begin
            tick();
            if (irq_out[4]) stray = 1;
        end
        chk("timer_stopped", 32'(stray), 32'd0);
        bus(BASE + 32'h10, 32'h0, 4'h0, 1'b1);
        bus(BASE + 32'hC, 32'h0, 4'h0, 1'b1);
`endif

        // random traffic
        rand_irq = 1;
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                w    = $urandom_range(0, 9);
                addr = BASE + 32'(w * 4);
                st   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                wd   = (w == 3) ? 32'($urandom_range(0, 40)) : $urandom;
                if ($urandom_range(0, 7) == 0) bus(addr + 32'h100, wd, st, 1'b0);
                else                           bus(addr, wd, st, 1'b1);
            end else begin
                tick();
            end
        end
        rand_irq = 0;
        irq_in = 32'h0;
        tick();

        // 6: reset lands on the accepting edge
        mem_valid = 1'b1; mem_addr = BASE + 32'h4; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'hF;
        m_access = 1'b1; resetn = 1'b0;
        tick();
        chk("t6_ready", 32'(mem_ready), 32'd0);
        mem_valid = 1'b0; mem_wstrb = 4'h0; resetn = 1'b1;
        tick();
        for (int o = 0; o <= 8; o++) bus(BASE + 32'(o * 4), 32'h0, 4'h0, 1'b1);
        tick(); tick();

        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
